// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings for the IF/MEM SRAM port arbiter: FSM states, owner tag and
// the stall-request pair handed to CTRL.
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam int WORD_W         = 32;
  localparam int WEN_W          = 4;
  localparam int STALLREQ_W     = 2;
  localparam int STALL_INST_BIT = 0;
  localparam int STALL_DATA_BIT = 1;

  function automatic logic [STALLREQ_W-1:0] pack_stallreq(input logic inst_s,
                                                          input logic data_s);
    return {data_s, inst_s};
  endfunction

endpackage

// File: rtl/sram_port_arbiter_arb_pick.sv
// Fair-priority picker: data beats inst unless inst has waited through
// DATA_RUN_MAX consecutive data grants. Purely combinational.
module sram_port_arbiter_arb_pick
  import sram_port_arbiter_pkg::*;
#(
  parameter int DATA_RUN_MAX = 4,
  parameter int CNT_W        = 3
) (
  input  logic             inst_req,
  input  logic             data_req,
  input  logic [CNT_W-1:0] run_cnt,
  output logic             grant,
  output owner_t           grant_owner,
  output logic [CNT_W-1:0] run_cnt_nxt
);

  localparam logic [CNT_W-1:0] RUN_MAX_C = CNT_W'(DATA_RUN_MAX);

  always_comb begin
    grant       = inst_req | data_req;
    grant_owner = OWN_DATA;
    run_cnt_nxt = run_cnt;
    if (inst_req && (!data_req || run_cnt == RUN_MAX_C)) begin
      grant_owner = OWN_INST;
    end
    // The run only counts data grants that made a waiting fetch wait longer.
    if (grant) begin
      if (!inst_req || grant_owner == OWN_INST) begin
        run_cnt_nxt = '0;
      end else if (run_cnt != RUN_MAX_C) begin
        run_cnt_nxt = run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the single-ported SRAM between instruction fetch and data access,
// one outstanding req/addr_ok/data_ok transaction at a time.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int DATA_RUN_MAX = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst_rdata,
  output logic              inst_rvalid,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_rvalid,
  output logic              mem_req,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [31:0]       mem_rdata,
  output logic              stallreq_inst,
  output logic              stallreq_data
);

  localparam int CNT_W = (DATA_RUN_MAX < 1) ? 1 : $clog2(DATA_RUN_MAX + 1);

  arb_state_t              state;
  owner_t                  owner;
  owner_t                  grant_owner;
  logic                    grant;
  logic [CNT_W-1:0]        run_cnt;
  logic [CNT_W-1:0]        run_cnt_nxt;
  logic                    complete;
  logic [STALLREQ_W-1:0]   stall_bus;

  sram_port_arbiter_arb_pick #(
    .DATA_RUN_MAX (DATA_RUN_MAX),
    .CNT_W        (CNT_W)
  ) u_pick (
    .inst_req    (inst_req),
    .data_req    (data_req),
    .run_cnt     (run_cnt),
    .grant       (grant),
    .grant_owner (grant_owner),
    .run_cnt_nxt (run_cnt_nxt)
  );

  // Accept and completion in the same ISSUE cycle skips WAIT entirely.
  assign complete = (state == ST_ISSUE && mem_addr_ok && mem_data_ok) ||
                    (state == ST_WAIT  && mem_data_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= OWN_INST;
      run_cnt     <= '0;
      mem_req     <= 1'b0;
      mem_wen     <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      inst_rdata  <= '0;
      data_rdata  <= '0;
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;
    end else begin
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;

      if (complete) begin
        if (owner == OWN_INST) begin
          inst_rdata  <= mem_rdata;
          inst_rvalid <= 1'b1;
        end else begin
          data_rdata  <= mem_rdata;
          data_rvalid <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (grant) begin
            owner   <= grant_owner;
            run_cnt <= run_cnt_nxt;
            mem_req <= 1'b1;
            state   <= ST_ISSUE;
            if (grant_owner == OWN_INST) begin
              mem_addr  <= inst_addr;
              mem_wen   <= '0;
              mem_wdata <= '0;
            end else begin
              mem_addr  <= data_addr;
              mem_wen   <= data_wen;
              mem_wdata <= data_wdata;
            end
          end
        end
        ST_ISSUE: begin
          if (mem_addr_ok) begin
            mem_req <= 1'b0;
            state   <= mem_data_ok ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_data_ok) begin
            state <= ST_RESP;
          end
        end
        // RESP never grants: the finishing requester still holds its stale req.
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall drops on the rvalid cycle so the pipeline consumes data on that edge.
  assign stall_bus     = pack_stallreq(inst_req & ~inst_rvalid,
                                       data_req & ~data_rvalid);
  assign stallreq_inst = stall_bus[STALL_INST_BIT];
  assign stallreq_data = stall_bus[STALL_DATA_BIT];

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: requester and SRAM models drive the
// DUT, expected responses are queued at issue and popped by a monitor.
module tb_sram_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int RUN_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [31:0]       inst_rdata;
  logic              inst_rvalid;
  logic              data_req;
  logic [3:0]        data_wen;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic [31:0]       data_rdata;
  logic              data_rvalid;
  logic              mem_req;
  logic [3:0]        mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [31:0]       mem_rdata;
  logic              stallreq_inst;
  logic              stallreq_data;

  sram_port_arbiter #(
    .DATA_RUN_MAX (RUN_MAX),
    .ADDR_W       (ADDR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_rdata    (inst_rdata),
    .inst_rvalid   (inst_rvalid),
    .data_req      (data_req),
    .data_wen      (data_wen),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_rdata    (data_rdata),
    .data_rvalid   (data_rvalid),
    .mem_req       (mem_req),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_addr_ok   (mem_addr_ok),
    .mem_data_ok   (mem_data_ok),
    .mem_rdata     (mem_rdata),
    .stallreq_inst (stallreq_inst),
    .stallreq_data (stallreq_data)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          own_data;
    bit          wr;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned rv_cyc_q[$];

  // Requester models
  int          inst_left = 0, data_left = 0;
  bit          inst_fix = 0, data_fix = 0;
  bit          inst_stale = 0, data_stale = 0;
  logic [31:0] inst_fix_addr, data_fix_addr, data_fix_wdata;
  logic [3:0]  data_fix_wen;
  int unsigned inst_start_cyc, data_start_cyc, last_inst_rv_cyc, last_data_rv_cyc;
  int unsigned n_inst_rv = 0;

  // SRAM model
  int          sram_phase = 0;
  int          aw_cnt, dd_cnt;
  int          force_aw = -1, force_dd = -1;
  bit          spur_en = 0;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_wen;

  // Arbitration reference: consecutive data grants while a fetch waited
  int          run = 0;
  string       grant_str = "";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %s want %s", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2408_0001;
    return {a[15:0] ^ 16'hA5C3, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic issue_check();
    bit win_data;
    lat_addr  = mem_addr;
    lat_wen   = mem_wen;
    lat_wdata = mem_wdata;
    if (!inst_req && !data_req) begin
      total++;
      bad++;
      $display("FAIL issue_without_req: got mem_req=1 want no grant (cycle %0d)", cyc);
      return;
    end
    win_data = data_req && !(inst_req && run == RUN_MAX);
    if (!inst_req || !win_data) run = 0;
    else if (run < RUN_MAX) run = run + 1;
    if (win_data) begin
      grant_str = {grant_str, "D"};
      chk("grant_data_addr", mem_addr, data_addr);
      chk("grant_data_wen", {28'd0, mem_wen}, {28'd0, data_wen});
      if (data_wen != 4'd0) chk("grant_data_wdata", mem_wdata, data_wdata);
      exp_q.push_back('{own_data: 1'b1, wr: (data_wen != 4'd0), rdata: ref_rd(data_addr)});
    end else begin
      grant_str = {grant_str, "I"};
      chk("grant_inst_addr", mem_addr, inst_addr);
      chk("grant_inst_wen", {28'd0, mem_wen}, 32'd0);
      exp_q.push_back('{own_data: 1'b0, wr: 1'b0, rdata: ref_rd(inst_addr)});
    end
  endtask

  task automatic data_now();
    mem_data_ok = 1'b1;
    mem_rdata   = ref_rd(lat_addr);
    sram_phase  = 0;
    rv_cyc_q.push_back(cyc + 1);
  endtask

  task automatic sram_step();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = $urandom;
    if (sram_phase == 0 && mem_req) begin
      issue_check();
      sram_phase = 1;
      aw_cnt = (force_aw >= 0) ? force_aw :
               (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
      dd_cnt = (force_dd >= 0) ? force_dd : int'($urandom_range(0, 3));
    end else if (sram_phase == 1) begin
      chk("req_held", {31'd0, mem_req}, 32'd1);
      chk("addr_stable", mem_addr, lat_addr);
      chk("wen_stable", {28'd0, mem_wen}, {28'd0, lat_wen});
      chk("wdata_stable", mem_wdata, lat_wdata);
    end else if (sram_phase == 2) begin
      chk("req_dropped", {31'd0, mem_req}, 32'd0);
    end

    if (sram_phase == 1) begin
      if (aw_cnt > 0) aw_cnt--;
      else begin
        mem_addr_ok = 1'b1;
        if (dd_cnt == 0) data_now();
        else sram_phase = 2;
      end
    end else if (sram_phase == 2) begin
      dd_cnt--;
      if (dd_cnt == 0) data_now();
    end else if (spur_en && !mem_req && $urandom_range(0, 7) == 0) begin
      mem_data_ok = 1'b1;
      mem_addr_ok = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic req_step();
    if (inst_req && inst_rvalid) inst_stale = 1;
    else if (!inst_req || inst_stale) begin
      inst_req   = 1'b0;
      inst_stale = 0;
      if (inst_left > 0 && (inst_fix || $urandom_range(0, 2) != 0)) begin
        inst_req       = 1'b1;
        inst_addr      = inst_fix ? inst_fix_addr : $urandom;
        inst_start_cyc = cyc;
        inst_left--;
      end
    end
    if (data_req && data_rvalid) data_stale = 1;
    else if (!data_req || data_stale) begin
      data_req   = 1'b0;
      data_stale = 0;
      if (data_left > 0 && (data_fix || $urandom_range(0, 2) != 0)) begin
        data_req       = 1'b1;
        data_addr      = data_fix ? data_fix_addr : $urandom;
        data_wdata     = data_fix ? data_fix_wdata : $urandom;
        data_wen       = data_fix ? data_fix_wen :
                         (($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0);
        data_start_cyc = cyc;
        data_left--;
      end
    end
  endtask

  task automatic cycle_step();
    @(posedge clk);
    #2;
    sram_step();
    if (inst_rvalid) last_inst_rv_cyc = cyc;
    if (data_rvalid) last_data_rv_cyc = cyc;
    req_step();
  endtask

  task automatic drain(input int limit, input string name);
    bit idle;
    idle = 0;
    for (int i = 0; i < limit; i++) begin
      idle = inst_left == 0 && data_left == 0 && !inst_req && !data_req &&
             sram_phase == 0 && exp_q.size() == 0;
      if (idle) break;
      cycle_step();
    end
    total++;
    if (!idle) begin
      bad++;
      $display("FAIL %s_timeout: got busy after %0d cycles want idle", name, limit);
    end
  endtask

  // Monitor: per-cycle stall rule, held rdata, and scoreboard pops on rvalid
  exp_t        e;
  logic [31:0] exp_inst_hold = '0;
  always @(negedge clk) begin
    if (rst) begin
      exp_inst_hold = '0;
    end else begin
      chk("stallreq_inst", {31'd0, stallreq_inst}, {31'd0, inst_req & ~inst_rvalid});
      chk("stallreq_data", {31'd0, stallreq_data}, {31'd0, data_req & ~data_rvalid});
      if (!inst_rvalid) chk("inst_rdata_hold", inst_rdata, exp_inst_hold);
      if (inst_rvalid && data_rvalid) begin
        total++;
        bad++;
        $display("FAIL dual_rvalid: got both rvalid want one (cycle %0d)", cyc);
      end else if (inst_rvalid || data_rvalid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_rvalid: got inst=%0d data=%0d want none (cycle %0d)",
                   inst_rvalid, data_rvalid, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("rvalid_owner", {31'd0, data_rvalid}, {31'd0, e.own_data});
          if (!e.own_data) begin
            chk("inst_rdata", inst_rdata, e.rdata);
            exp_inst_hold = e.rdata;
            n_inst_rv++;
          end else if (!e.wr) begin
            chk("data_rdata", data_rdata, e.rdata);
          end
          if (rv_cyc_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rvalid_before_data_ok: got rvalid at %0d want data_ok first", cyc);
          end else begin
            chk("rvalid_cycle", cyc, rv_cyc_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n_before;
    rst         = 1'b1;
    inst_req    = 1'b0;
    inst_addr   = '0;
    data_req    = 1'b0;
    data_wen    = '0;
    data_addr   = '0;
    data_wdata  = '0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_wen", {28'd0, mem_wen}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    chk("rst_rvalids", {30'd0, inst_rvalid, data_rvalid}, 32'd0);
    rst = 1'b0;

    // Single fetch, addr_ok at issue, data_ok one cycle later
    force_aw = 0; force_dd = 1;
    inst_fix = 1; inst_fix_addr = 32'hBFC0_0000; inst_left = 1;
    drain(100, "single_read");
    chk("read_latency", last_inst_rv_cyc - inst_start_cyc, 32'd3);

    // Simultaneous fetch and load: data first
    grant_str = "";
    data_fix = 1; data_fix_addr = 32'h8000_0010; data_fix_wen = 4'd0; data_fix_wdata = '0;
    inst_fix_addr = 32'hBFC0_0004;
    data_left = 1; inst_left = 1;
    drain(100, "simultaneous");
    chk_str("simultaneous_order", grant_str, "DI");

    // Store with addr_ok withheld for three cycles
    force_aw = 3; force_dd = 1;
    data_fix_addr = 32'h8000_0020; data_fix_wen = 4'b0011; data_fix_wdata = 32'h0000_BEEF;
    data_left = 1;
    drain(100, "store");
    chk("store_latency", last_data_rv_cyc - data_start_cyc, 32'd6);

    // Starvation: inst must win after DATA_RUN_MAX data grants
    force_aw = 0; force_dd = 0;
    grant_str = "";
    data_fix_addr = 32'h8000_0040; data_fix_wen = 4'd0;
    inst_fix_addr = 32'hBFC0_0008;
    data_left = 5; inst_left = 1;
    drain(200, "starvation");
    chk_str("starvation_order", grant_str, "DDDDID");

    // Same-cycle addr_ok and data_ok: no WAIT cycle
    inst_fix_addr = 32'hBFC0_000C; inst_left = 1;
    drain(100, "same_cycle");
    chk("same_cycle_latency", last_inst_rv_cyc - inst_start_cyc, 32'd2);

    // Reset while waiting for data
    force_aw = 0; force_dd = 6;
    inst_fix_addr = 32'hBFC0_0010; inst_left = 1;
    for (int i = 0; i < 20 && sram_phase != 2; i++) cycle_step();
    chk("reached_wait", sram_phase, 32'd2);
    @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_rst_rvalids", {30'd0, inst_rvalid, data_rvalid}, 32'd0);
    exp_q.delete();
    rv_cyc_q.delete();
    sram_phase = 0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    inst_req = 1'b0; inst_left = 0; inst_stale = 0;
    data_req = 1'b0; data_left = 0; data_stale = 0;
    run = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    n_before = n_inst_rv;
    force_dd = 1;
    inst_fix_addr = 32'hBFC0_0014; inst_left = 1;
    drain(100, "post_reset");
    chk("post_reset_resp", n_inst_rv - n_before, 32'd1);

    // Randomized traffic with random SRAM timing and stray handshakes
    force_aw = -1; force_dd = -1;
    inst_fix = 0; data_fix = 0; spur_en = 1;
    inst_left = 80; data_left = 80;
    drain(5000, "random");
    spur_en = 0;
    repeat (3) cycle_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
